// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: drives one load / capture / unload sequence on an external scan chain.
//
// Sequence after START is accepted in IDLE:
//   SHIFT   CHAIN_LEN cycles, SE=1, SI walks PATTERN from bit CHAIN_LEN-1 down to bit 0
//   CAPTURE one cycle, SE=0, chain loads its functional D inputs
//   UNLOAD  CHAIN_LEN cycles, SE=1, SO shifted into RESULT from the LSB end
//   DONE    one-cycle pulse, back in IDLE, RESULT valid
//
// Ports:
//   CLK      clock, rising edge
//   RN       asynchronous active-low reset
//   START    request a sequence (ignored while BUSY)
//   PATTERN  stimulus, bit i ends up in chain flop i (flop 0 nearest SI)
//   SO       Q of the last chain flop
//   SE, SI   scan enable / scan data to the chain
//   BUSY     high whenever not IDLE
//   DONE     one-cycle pulse, RESULT valid
//   RESULT   captured response, bit i captured by flop i
//   EXPECT   (SCAN_CHAIN_CTRL_COMPARE_EN only) expected response, sampled with START
//   FAIL     (SCAN_CHAIN_CTRL_COMPARE_EN only) RESULT != EXPECT, updated with DONE
//
// Optional feature macro: SCAN_CHAIN_CTRL_COMPARE_EN
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic                 SO,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] EXPECT,
  output logic                 FAIL,
`endif
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESULT
);

  typedef enum logic [1:0] {StIdle, StShift, StCapture, StUnload} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CHAIN_LEN-1:0]   pat_q;
  logic                   se_q;
  logic                   si_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CHAIN_LEN-1:0]   result_q;
  logic                   cnt_last;
  logic [CHAIN_LEN-1:0]   result_shift;

  assign cnt_last     = (cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign result_shift = {result_q[CHAIN_LEN-2:0], SO};

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] expect_q;
  logic                 fail_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      expect_q <= '0;
      fail_q   <= 1'b0;
    end else begin
      if (state_q == StIdle && START) begin
        expect_q <= EXPECT;
      end
      if (state_q == StUnload && cnt_last) begin
        fail_q <= (result_shift != expect_q);
      end
    end
  end

  assign FAIL = fail_q;
`else
  // No compare logic: RESULT is the only observable outcome.
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pat_q    <= '0;
      se_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q <= StShift;
            se_q    <= 1'b1;
            si_q    <= PATTERN[CHAIN_LEN-1];
            // Keep the pattern pre-shifted so the next SI bit is always the MSB.
            pat_q   <= {PATTERN[CHAIN_LEN-2:0], 1'b0};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          if (cnt_last) begin
            state_q <= StCapture;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            si_q  <= pat_q[CHAIN_LEN-1];
            pat_q <= {pat_q[CHAIN_LEN-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCapture: begin
          state_q <= StUnload;
          se_q    <= 1'b1;
          si_q    <= 1'b0;
          cnt_q   <= '0;
        end
        StUnload: begin
          // SO here is the value before this edge, i.e. flop CHAIN_LEN-1-cnt of the capture.
          result_q <= result_shift;
          if (cnt_last) begin
            state_q <= StIdle;
            se_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          se_q    <= 1'b0;
          si_q    <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign SE     = se_q;
  assign SI     = si_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: a 4-flop and a 2-flop behavioural scan chain hang off two
// instances; expected responses come from what the chain's D function does to the pattern.
module tb_scan_chain_ctrl;

  localparam int L  = 4;
  localparam int L2 = 2;

  logic clk;
  logic rn;

  logic         start1, so1, se1, si1, busy1, done1;
  logic [L-1:0] pat1, res1, expect1, chain1;
  bit           inv1;

  logic          start2, so2, se2, si2, busy2, done2;
  logic [L2-1:0] pat2, res2, expect2, chain2;
  bit            inv2;

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  logic fail1, fail2;
`endif

  int checks;
  int errors;
  logic [L-1:0] last_res;

  scan_chain_ctrl #(.CHAIN_LEN(L)) u_dut4 (
    .CLK     (clk),
    .RN      (rn),
    .START   (start1),
    .PATTERN (pat1),
    .SO      (so1),
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    .EXPECT  (expect1),
    .FAIL    (fail1),
`endif
    .SE      (se1),
    .SI      (si1),
    .BUSY    (busy1),
    .DONE    (done1),
    .RESULT  (res1)
  );

  scan_chain_ctrl #(.CHAIN_LEN(L2)) u_dut2 (
    .CLK     (clk),
    .RN      (rn),
    .START   (start2),
    .PATTERN (pat2),
    .SO      (so2),
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    .EXPECT  (expect2),
    .FAIL    (fail2),
`endif
    .SE      (se2),
    .SI      (si2),
    .BUSY    (busy2),
    .DONE    (done2),
    .RESULT  (res2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External chains: shift on SE, otherwise load D = ~Q (inv) or D = Q.
  always @(posedge clk) begin
    if (se1) chain1 <= {chain1[L-2:0], si1};
    else if (inv1) chain1 <= ~chain1;
    if (se2) chain2 <= {chain2[L2-2:0], si2};
    else if (inv2) chain2 <= ~chain2;
  end
  assign so1 = chain1[L-1];
  assign so2 = chain2[L2-1];

  typedef struct {
    logic [L-1:0] pattern;
    bit           inv;
    logic [L-1:0] result;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // What the chain returns: each flop captures D from the loaded pattern bit.
  function automatic logic [L-1:0] model_result(input logic [L-1:0] p, input bit inv);
    return inv ? ~p : p;
  endfunction

  // Caller must be between a negedge and the next posedge.
  task automatic run_seq(input logic [L-1:0] p, input bit inv, input logic [L-1:0] e,
                         input bit poke);
    logic [L-1:0] want;
    logic [L-1:0] ptmp;
    logic         exp_si;
    logic         exp_se;
    want    = model_result(p, inv);
    inv1    = inv;
    start1  = 1'b1;
    pat1    = p;
    expect1 = e;
    @(posedge clk);
    #1;
    start1  = 1'b0;
    pat1    = L'($urandom);
    expect1 = L'($urandom);
    for (int k = 0; k <= 2 * L + 1; k++) begin
      @(negedge clk);
      ptmp   = p >> (L - 1 - (k < L ? k : 0));
      exp_si = (k < L) ? ptmp[0] : 1'b0;
      exp_se = (k < L) || (k > L && k < 2 * L + 1);
      check("ctl_se_si_busy_done", {28'd0, se1, si1, busy1, done1},
            {28'd0, exp_se, exp_si, (k < 2 * L + 1), (k == 2 * L + 1)});
      if (k <= L + 1) check("result_hold", res1, last_res);
      start1 = poke && (k == 1 || k == L);
    end
    check("result", res1, want);
    last_res = want;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    check("fail_flag", fail1, (want != e));
`endif
    start1 = 1'b0;
    @(negedge clk);
    check("after_done", {30'd0, busy1, done1}, 32'd0);
  endtask

  initial begin
    vec_t       vecs[$];
    int         dones[$];
    int         idle_cnt;
    int         seen;
    int         k2;
    logic [L-1:0] rp;
    bit         rinv;

    checks   = 0;
    errors   = 0;
    last_res = '0;
    rn       = 1'b0;
    start1   = 1'b0;
    start2   = 1'b0;
    pat1     = '0;
    pat2     = '0;
    expect1  = '0;
    expect2  = '0;
    inv1     = 1'b0;
    inv2     = 1'b0;

    vecs.push_back('{4'b1010, 1'b1, 4'b0101});
    vecs.push_back('{4'b1010, 1'b0, 4'b1010});
    vecs.push_back('{4'b0000, 1'b1, 4'b1111});
    vecs.push_back('{4'b1111, 1'b0, 4'b1111});
    vecs.push_back('{4'b0011, 1'b1, 4'b1100});
    vecs.push_back('{4'b1000, 1'b0, 4'b1000});

    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, se1, si1, busy1, done1, res1},
          32'd0);
    check("reset_outputs_l2", {26'd0, se2, si2, busy2, done2, res2}, 32'd0);
    rn = 1'b1;

    // Table vectors, the first one also pokes START during SHIFT and CAPTURE.
    foreach (vecs[i]) run_seq(vecs[i].pattern, vecs[i].inv, vecs[i].result, (i == 0));

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    run_seq(4'b1010, 1'b1, 4'b0101, 1'b0);
    run_seq(4'b1010, 1'b1, 4'b0111, 1'b0);
`endif

    // Randomised sequences against the model.
    for (int n = 0; n < 12; n++) begin
      rp   = L'($urandom);
      rinv = 1'($urandom);
      run_seq(rp, rinv, L'($urandom), 1'($urandom));
    end

    // START held high: DONE every 2*L+2 cycles, BUSY low only in the DONE cycle.
    inv1     = 1'b1;
    pat1     = 4'b1010;
    start1   = 1'b1;
    idle_cnt = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (!busy1) idle_cnt++;
      if (done1) begin
        dones.push_back(c);
        check("b2b_result", res1, 4'b0101);
      end
    end
    start1 = 1'b0;
    check("b2b_done_count", dones.size(), 3);
    for (int i = 0; i < dones.size() && i < 3; i++)
      check("b2b_done_cycle", dones[i], 10 * (i + 1));
    check("b2b_idle_cycles", idle_cnt, 3);
    seen = 0;
    for (int c = 0; c < 30 && busy1; c++) @(negedge clk);
    check("b2b_drain", busy1, 1'b0);
    last_res = 4'b0101;

    // Reset during UNLOAD after two samples.
    inv1   = 1'b0;
    start1 = 1'b1;
    pat1   = 4'b0110;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (L + 4) @(negedge clk);
    check("abort_busy_pre", busy1, 1'b1);
    rn = 1'b0;
    #1;
    check("abort_outputs", {25'd0, se1, si1, busy1, done1, res1}, 32'd0);
    last_res = '0;
    @(negedge clk);
    rn = 1'b1;
    // First edge with RN high must accept START.
    run_seq(4'b1101, 1'b1, 4'b0010, 1'b0);

    // Two-flop chain with D = Q.
    inv2   = 1'b0;
    pat2   = 2'b01;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    pat2   = 2'b10;
    k2     = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done2 && k2 < 0) begin
        k2 = k;
        check("l2_result", res2, 2'b01);
      end
    end
    check("l2_done_latency", k2, 2 * L2 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
